// File: rtl/eq_serial_sched.sv
// Round-robin scheduler that shares one 1-bit equality cell between two requesters.
// Optional macro EQ_SCHED_EARLY_EXIT_EN: finish as soon as a bit mismatch is seen.
module eq_serial_sched #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         eq,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          owner;
    logic          last;
    logic          eq_bit;
    logic          grant_any;
    logic          grant_sel;
    logic          finish;

    // The single shared equality cell.
    assign eq_bit = (sa[0] == sb[0]);
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        grant_sel  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_any  = 1'b1;
                    // On a tie, the requester that did not win last time goes first.
                    grant_sel  = req1 && (!req0 || !last);
                    state_next = CMP;
                end
            end
            CMP: begin
                if (cnt == CW'(N - 1)) begin
                    finish = 1'b1;
                end
`ifdef EQ_SCHED_EARLY_EXIT_EN
                if (!eq_bit) begin
                    finish = 1'b1;
                end
`endif
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            acc   <= 1'b0;
            owner <= 1'b0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            eq    <= 1'b0;
        end else begin
            state <= state_next;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (grant_any) begin
                sa    <= grant_sel ? a1 : a0;
                sb    <= grant_sel ? b1 : b0;
                cnt   <= '0;
                acc   <= 1'b1;
                owner <= grant_sel;
                last  <= grant_sel;
                gnt0  <= !grant_sel;
                gnt1  <= grant_sel;
            end else if (state == CMP) begin
                acc <= acc & eq_bit;
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                cnt <= cnt + CW'(1);
                if (finish) begin
                    eq    <= acc & eq_bit;
                    done0 <= !owner;
                    done1 <= owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_eq_serial_sched.sv
// Directed self-checking bench for eq_serial_sched (N = 8), with expectations for
// both the default build and the EQ_SCHED_EARLY_EXIT_EN build.
module tb_eq_serial_sched;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic         eq;
    logic         busy;

    int total = 0;
    int bad   = 0;

    eq_serial_sched #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .eq      (eq),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Outputs are sampled on the falling edge, between active edges.
    task automatic test_reset();
        logic [5:0] outs;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        outs = {gnt0, gnt1, done0, done1, eq, busy};
        total++;
        if (outs !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want %b", outs, 6'b0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_cmp();
        logic [5:0] outs;
        logic       seen;
        a0 = 8'hA5; b0 = 8'hA5; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midcmp_busy_before: got %b want 1", busy);
        end
        reset_n = 1'b0;
        #1;
        outs = {gnt0, gnt1, done0, done1, eq, busy};
        total++;
        if (outs !== 6'b0) begin
            bad++;
            $display("[TB] FAIL midcmp_async_clear: got %b want %b", outs, 6'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done0 || done1 || busy || gnt0 || gnt1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midcmp_no_activity_after: got %b want 0", seen);
        end
    endtask

    task automatic test_single_req0();
        logic early;
        a0 = 8'hA5; b0 = 8'hA5; req0 = 1'b1;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL single0_grant: got %b want 101", {gnt0, gnt1, busy});
        end
        req0 = 1'b0;
        early = 1'b0;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            if (done0 || done1 || gnt0) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single0_quiet_during_cmp: got %b want 0", early);
        end
        @(negedge clk);
        total++;
        if ({done0, done1, eq} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL single0_done: got %b want 101", {done0, done1, eq});
        end
        @(negedge clk);
        total++;
        if ({done0, eq, busy} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL single0_after_done: got %b want 010", {done0, eq, busy});
        end
        @(negedge clk);
        total++;
        if (eq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single0_eq_holds: got %b want 1", eq);
        end
    endtask

    task automatic test_single_req1_msb();
        logic early;
        a1 = 8'h3C; b1 = 8'hBC; req1 = 1'b1;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL single1_grant: got %b want 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        early = 1'b0;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            if (done0 || done1) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single1_no_early_done: got %b want 0", early);
        end
        @(negedge clk);
        total++;
        if ({done0, done1, eq} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL single1_done: got %b want 010", {done0, done1, eq});
        end
        repeat (2) @(negedge clk);
        total++;
        if ({eq, busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL single1_eq_holds: got %b want 00", {eq, busy});
        end
    endtask

    task automatic test_back_to_back();
        int         gi;
        int         di;
        int         last_grant;
        logic       who;
        logic       both_seen;
        a0 = 8'h11; b0 = 8'h11;
        a1 = 8'h22; b1 = 8'hA2;
        req0 = 1'b1; req1 = 1'b1;
        gi = 0; di = 0; last_grant = 0; both_seen = 1'b0;
        for (int cyc = 1; cyc <= 4 * (N + 2) + 6; cyc++) begin
            @(negedge clk);
            if ((gnt0 && gnt1) || (done0 && done1)) both_seen = 1'b1;
            if (gnt0 || gnt1) begin
                who = gnt1;
                total++;
                if (who !== gi[0]) begin
                    bad++;
                    $display("[TB] FAIL b2b_grant_order[%0d]: got %0d want %0d", gi, who, gi[0]);
                end
                if (gi > 0) begin
                    total++;
                    if (cyc - last_grant != N + 2) begin
                        bad++;
                        $display("[TB] FAIL b2b_grant_spacing[%0d]: got %0d want %0d", gi, cyc - last_grant, N + 2);
                    end
                end
                last_grant = cyc;
                gi++;
                if (gi == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
            if (done0 || done1) begin
                who = done1;
                total++;
                if ({who, eq} !== {di[0], ~di[0]}) begin
                    bad++;
                    $display("[TB] FAIL b2b_done_owner_eq[%0d]: got %b want %b", di, {who, eq}, {di[0], ~di[0]});
                end
                di++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (gi != 4 || di != 4 || both_seen) begin
            bad++;
            $display("[TB] FAIL b2b_counts: got grants=%0d dones=%0d both=%b want 4 4 0", gi, di, both_seen);
        end
    endtask

    task automatic test_capture_and_drop();
        logic seen;
        a0 = 8'h5A; b0 = 8'h5A; req0 = 1'b1;
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL capture_grant: got %b want 1", gnt0);
        end
        a0 = 8'h00; b0 = 8'hFF;
        repeat (2) @(negedge clk);
        req0 = 1'b0;
        seen = 1'b0;
        for (int i = 3; i < N; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        @(negedge clk);
        total++;
        if ({seen, done0, eq} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL capture_result: got %b want 011", {seen, done0, eq});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_exit();
        int   done_at;
        a0 = 8'h01; b0 = 8'h00; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        total++;
        if (gnt0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lsb_mismatch_grant: got %b want 1", gnt0);
        end
        done_at = 0;
        for (int i = 1; i <= N + 1; i++) begin
            @(negedge clk);
            if (done0 && done_at == 0) begin
                done_at = i;
                total++;
                if (eq !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL lsb_mismatch_eq: got %b want 0", eq);
                end
`ifdef EQ_SCHED_EARLY_EXIT_EN
                a0 = 8'h77; b0 = 8'h77; req0 = 1'b1;
`endif
            end
`ifdef EQ_SCHED_EARLY_EXIT_EN
            if (i == 3) begin
                req0 = 1'b0;
                total++;
                if (gnt0 !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL early_next_grant: got %b want 1", gnt0);
                end
            end
`endif
        end
`ifdef EQ_SCHED_EARLY_EXIT_EN
        total++;
        if (done_at != 1) begin
            bad++;
            $display("[TB] FAIL early_done_edge: got %0d want 1", done_at);
        end
`else
        total++;
        if (done_at != N) begin
            bad++;
            $display("[TB] FAIL full_done_edge: got %0d want %0d", done_at, N);
        end
`endif
        req0 = 1'b0;
        repeat (N + 3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL final_idle: got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_cmp();
        test_single_req0();
        test_single_req1_msb();
        test_back_to_back();
        test_capture_and_drop();
        test_early_exit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
